// File: rtl/hyper_tape_pkg.sv
// Shared constants for the fast-tape I/O port: mode encodings, register offsets,
// STATUS bit positions and the value returned when there is nothing to read.
package hyper_tape_pkg;

    typedef enum logic [1:0] {
        MODE_IDLE = 2'b00,
        MODE_LOAD = 2'b01,
        MODE_SAVE = 2'b10,
        MODE_DONE = 2'b11
    } mode_e;

    localparam logic [7:0] OFS_STATUS = 8'd0;
    localparam logic [7:0] OFS_DATA   = 8'd1;
    localparam logic [7:0] OFS_CTRL   = 8'd2;
    localparam logic [7:0] OFS_CSUM   = 8'd3;

    localparam int ST_RX_AVAIL = 0;
    localparam int ST_TX_SPACE = 1;
    localparam int ST_RX_END   = 2;
    localparam int ST_MODE_LO  = 4;
    localparam int ST_CSUM_NZ  = 6;

    localparam logic [1:0] CTRL_IDLE = 2'b00;
    localparam logic [1:0] CTRL_LOAD = 2'b01;
    localparam logic [1:0] CTRL_SAVE = 2'b10;

    localparam logic [7:0] EMPTY_RD = 8'hFF;

endpackage

// File: rtl/hyper_tape_port_if.sv
// Z80 I/O bus plus host-side load/save streams of the fast-tape port.
// slave = the port itself, master = the CPU/host side driving it.
interface hyper_tape_port_if;
    logic       override;
    logic [7:0] io_addr;
    logic       iorq_n;
    logic       rd_n;
    logic       wr_n;
    logic [7:0] io_din;
    logic [7:0] io_dout;
    logic       io_oe;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       rx_eof;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [1:0] mode;

    modport slave (
        input  override, io_addr, iorq_n, rd_n, wr_n, io_din,
        input  rx_data, rx_valid, rx_eof, tx_ready,
        output io_dout, io_oe, rx_ready, tx_data, tx_valid, mode
    );

    modport master (
        output override, io_addr, iorq_n, rd_n, wr_n, io_din,
        output rx_data, rx_valid, rx_eof, tx_ready,
        input  io_dout, io_oe, rx_ready, tx_data, tx_valid, mode
    );
endinterface

// File: rtl/hyper_tape_fifo.sv
// Synchronous FIFO with exact full/empty from a count one bit wider than the
// pointers; clear empties it in one cycle and wins over push/pop.
module hyper_tape_fifo #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clear_i,
    input  logic              push_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              pop_i,
    output logic              full_o,
    output logic              empty_o,
    output logic [DATA_W-1:0] head_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CNT_FULL = DEPTH[AW:0];

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wptr_q, rptr_q;
    logic [AW:0]       cnt_q;
    logic              do_push, do_pop;

    assign full_o  = (cnt_q == CNT_FULL);
    assign empty_o = (cnt_q == '0);
    assign head_o  = mem_q[rptr_q];
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_ff @(posedge clk) begin
        if (!reset_n || clear_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Storage carries no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= data_i;
    end
endmodule

// File: rtl/hyper_tape_port.sv
// Z80 I/O responder for the ROM fast-tape routines: load bytes buffered from the
// host, save bytes buffered to the host. Macro HYPER_TAPE_CHECKSUM_EN adds a running sum at +3.
module hyper_tape_port
    import hyper_tape_pkg::*;
#(
    parameter logic [7:0] PORT_BASE  = 8'hE0,
    parameter int         FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    hyper_tape_port_if.slave bus
);
`ifdef HYPER_TAPE_CHECKSUM_EN
    localparam logic [7:0] OFS_LAST = OFS_CSUM;
    logic [7:0] csum_q, csum_d;
`else
    localparam logic [7:0] OFS_LAST = OFS_CTRL;
`endif

    mode_e      mode_q, mode_d;
    logic       exit_q, exit_d;
    logic       rd_q, wr_q;
    logic [7:0] dout_q, dout_d;
    logic [7:0] ofs, status, rx_head, tx_head;
    logic       sel, rd_stb, wr_stb, ctrl_wr;
    logic       rx_pop, rx_push, rx_clr, rx_full, rx_empty, rx_rdy;
    logic       tx_pop, tx_push, tx_clr, tx_full, tx_empty;

    // Offset wraps modulo 256, so a base near 8'hFF still decodes correctly.
    assign ofs     = bus.io_addr - PORT_BASE;
    assign sel     = bus.override & ~bus.iorq_n & (ofs <= OFS_LAST);
    assign rd_stb  = sel & ~bus.rd_n & rd_q;
    assign wr_stb  = sel & ~bus.wr_n & wr_q;
    assign ctrl_wr = wr_stb & (ofs == OFS_CTRL) & (bus.io_din[1:0] != 2'b11);
    assign rx_pop  = rd_stb & (ofs == OFS_DATA) & (mode_q == MODE_LOAD) & ~rx_empty;
    assign tx_push = wr_stb & (ofs == OFS_DATA) & (mode_q == MODE_SAVE) & ~tx_full;
    assign rx_rdy  = (mode_q == MODE_LOAD) & ~rx_full;
    assign rx_push = bus.rx_valid & rx_rdy;
    assign tx_pop  = ~tx_empty & bus.tx_ready;

    assign bus.io_oe    = sel & ~bus.rd_n;
    assign bus.io_dout  = dout_q;
    assign bus.rx_ready = rx_rdy;
    assign bus.tx_valid = ~tx_empty;
    assign bus.tx_data  = tx_empty ? 8'h00 : tx_head;
    assign bus.mode     = mode_q;

    always_comb begin
        status                  = 8'h00;
        status[ST_RX_AVAIL]     = ~rx_empty;
        status[ST_TX_SPACE]     = ~tx_full;
        status[ST_RX_END]       = bus.rx_eof & rx_empty;
        status[ST_MODE_LO +: 2] = mode_q;
`ifdef HYPER_TAPE_CHECKSUM_EN
        status[ST_CSUM_NZ]      = (csum_q != 8'h00);
`endif
    end

    always_comb begin
        dout_d = EMPTY_RD;
        case (ofs)
            OFS_STATUS: dout_d = status;
            OFS_DATA:   if ((mode_q == MODE_LOAD) && !rx_empty) dout_d = rx_head;
`ifdef HYPER_TAPE_CHECKSUM_EN
            OFS_CSUM:   dout_d = csum_q;
`endif
            default:    dout_d = EMPTY_RD;
        endcase
    end

    // exit_q marks a SAVE->IDLE request still waiting for the tx FIFO to drain.
    always_comb begin
        mode_d = mode_q;
        exit_d = exit_q;
        rx_clr = 1'b0;
        tx_clr = 1'b0;
        if (!bus.override) begin
            mode_d = MODE_IDLE;
            exit_d = 1'b0;
            rx_clr = 1'b1;
        end else if (ctrl_wr) begin
            case (bus.io_din[1:0])
                CTRL_LOAD: begin
                    mode_d = MODE_LOAD;
                    exit_d = 1'b0;
                    rx_clr = 1'b1;
                end
                CTRL_SAVE: begin
                    mode_d = MODE_SAVE;
                    exit_d = 1'b0;
                    tx_clr = 1'b1;
                end
                default: begin
                    rx_clr = 1'b1;
                    if ((mode_q == MODE_SAVE) && !tx_empty) begin
                        exit_d = 1'b1;
                    end else begin
                        mode_d = MODE_IDLE;
                        exit_d = 1'b0;
                    end
                end
            endcase
        end else if ((mode_q == MODE_LOAD) && bus.rx_eof && rx_empty) begin
            mode_d = MODE_DONE;
        end else if (exit_q && tx_empty) begin
            mode_d = MODE_IDLE;
            exit_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            mode_q <= MODE_IDLE;
            exit_q <= 1'b0;
            rd_q   <= 1'b1;
            wr_q   <= 1'b1;
            dout_q <= 8'h00;
        end else begin
            mode_q <= mode_d;
            exit_q <= exit_d;
            rd_q   <= bus.rd_n;
            wr_q   <= bus.wr_n;
            if (rd_stb) dout_q <= dout_d;
        end
    end

`ifdef HYPER_TAPE_CHECKSUM_EN
    always_comb begin
        csum_d = csum_q;
        if (ctrl_wr)      csum_d = 8'h00;
        else if (rx_pop)  csum_d = csum_q + rx_head;
        else if (tx_push) csum_d = csum_q + bus.io_din;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) csum_q <= 8'h00;
        else          csum_q <= csum_d;
    end
`endif

    hyper_tape_fifo #(.DEPTH(FIFO_DEPTH), .DATA_W(8)) u_rx_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .clear_i (rx_clr),
        .push_i  (rx_push),
        .data_i  (bus.rx_data),
        .pop_i   (rx_pop),
        .full_o  (rx_full),
        .empty_o (rx_empty),
        .head_o  (rx_head)
    );

    hyper_tape_fifo #(.DEPTH(FIFO_DEPTH), .DATA_W(8)) u_tx_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .clear_i (tx_clr),
        .push_i  (tx_push),
        .data_i  (bus.io_din),
        .pop_i   (tx_pop),
        .full_o  (tx_full),
        .empty_o (tx_empty),
        .head_o  (tx_head)
    );
endmodule

// File: tb/tb_hyper_tape_port.sv
// Bench for hyper_tape_port: directed steps plus randomized bytes, checked against a
// queue-based model of the port; the +3 checksum steps follow HYPER_TAPE_CHECKSUM_EN.
`timescale 1ns/1ps
module tb_hyper_tape_port;
    localparam logic [7:0] BASE  = 8'hE0;
    localparam int         DEPTH = 4;
    localparam logic [1:0] M_IDLE = 2'b00, M_LOAD = 2'b01, M_SAVE = 2'b10, M_DONE = 2'b11;
`ifdef HYPER_TAPE_CHECKSUM_EN
    localparam logic [7:0] LAST_OFS = 8'd3;
`else
    localparam logic [7:0] LAST_OFS = 8'd2;
`endif

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    hyper_tape_port_if bus_if();

    hyper_tape_port #(.PORT_BASE(BASE), .FIFO_DEPTH(DEPTH)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_if)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0] host_q[$];
    logic [7:0] mrx[$];
    logic [7:0] mtx[$];
    logic [7:0] txlog[$];
    logic [1:0] mmode = M_IDLE;
    bit         mpend = 1'b0;
    logic [7:0] msum  = 8'h00;
    logic [7:0] mdout = 8'h00;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] mstatus();
        logic [7:0] s;
        s      = 8'h00;
        s[0]   = (mrx.size() != 0);
        s[1]   = (mtx.size() < DEPTH);
        s[2]   = bus_if.rx_eof && (mrx.size() == 0);
        s[5:4] = mmode;
`ifdef HYPER_TAPE_CHECKSUM_EN
        s[6]   = (msum != 8'h00);
`endif
        return s;
    endfunction

    // One clock: check stream outputs against the model, then advance the model.
    task automatic tick();
        bit rf, tf, ov;
        logic [1:0] nmode;
        #1;
        check("rx_ready", bus_if.rx_ready, (mmode == M_LOAD) && (mrx.size() < DEPTH));
        check("tx_valid", bus_if.tx_valid, mtx.size() > 0);
        check("mode", bus_if.mode, mmode);
        ov = bus_if.override;
        rf = bus_if.rx_valid && (mmode == M_LOAD) && (mrx.size() < DEPTH);
        tf = bus_if.tx_ready && (mtx.size() > 0);
        if (tf) check("tx_data", bus_if.tx_data, mtx[0]);
        nmode = mmode;
        if (!ov) begin
            nmode = M_IDLE;
            mpend = 1'b0;
        end else if ((mmode == M_LOAD) && bus_if.rx_eof && (mrx.size() == 0)) begin
            nmode = M_DONE;
        end else if (mpend && (mtx.size() == 0)) begin
            nmode = M_IDLE;
            mpend = 1'b0;
        end
        @(negedge clk);
        if (tf) begin
            txlog.push_back(mtx[0]);
            void'(mtx.pop_front());
        end
        if (rf) begin
            if (ov) mrx.push_back(host_q[0]);
            void'(host_q.pop_front());
        end
        if (!ov) mrx.delete();
        mmode = nmode;
        bus_if.rx_valid = (host_q.size() > 0);
        bus_if.rx_data  = (host_q.size() > 0) ? host_q[0] : 8'h00;
    endtask

    task automatic io_read(input logic [7:0] ofs, input int hold, input string tag,
                           output logic [7:0] obs);
        bit sel_m, pop;
        logic [7:0] exp;
        sel_m = bus_if.override && (ofs <= LAST_OFS);
        pop   = 1'b0;
        exp   = mdout;
        if (sel_m) begin
            case (ofs)
                8'd0: exp = mstatus();
                8'd1: begin
                    if ((mmode == M_LOAD) && (mrx.size() > 0)) begin
                        exp = mrx[0];
                        pop = 1'b1;
                    end else begin
                        exp = 8'hFF;
                    end
                end
                8'd3: exp = msum;
                default: exp = 8'hFF;
            endcase
        end
        bus_if.io_addr = BASE + ofs;
        bus_if.iorq_n  = 1'b0;
        bus_if.rd_n    = 1'b0;
        #1;
        check({tag, "_oe"}, bus_if.io_oe, sel_m);
        tick();
        if (pop) begin
            void'(mrx.pop_front());
            msum = msum + exp;
        end
        mdout = exp;
        repeat (hold - 1) tick();
        obs = bus_if.io_dout;
        check(tag, obs, exp);
        bus_if.rd_n   = 1'b1;
        bus_if.iorq_n = 1'b1;
        tick();
    endtask

    task automatic io_write(input logic [7:0] ofs, input logic [7:0] data);
        bit sel_m, push, ctrl, txe;
        logic [1:0] was;
        sel_m = bus_if.override && (ofs <= LAST_OFS);
        push  = sel_m && (ofs == 8'd1) && (mmode == M_SAVE) && (mtx.size() < DEPTH);
        ctrl  = sel_m && (ofs == 8'd2) && (data[1:0] != 2'b11);
        txe   = (mtx.size() == 0);
        was   = mmode;
        bus_if.io_addr = BASE + ofs;
        bus_if.io_din  = data;
        bus_if.iorq_n  = 1'b0;
        bus_if.wr_n    = 1'b0;
        #1;
        check("wr_oe", bus_if.io_oe, 1'b0);
        tick();
        if (push) begin
            mtx.push_back(data);
            msum = msum + data;
        end
        if (ctrl) begin
            msum = 8'h00;
            case (data[1:0])
                2'b01: begin mmode = M_LOAD; mpend = 1'b0; mrx.delete(); end
                2'b10: begin mmode = M_SAVE; mpend = 1'b0; mtx.delete(); end
                default: begin
                    mrx.delete();
                    if ((was == M_SAVE) && !txe) mpend = 1'b1;
                    else begin mmode = M_IDLE; mpend = 1'b0; end
                end
            endcase
        end
        bus_if.wr_n   = 1'b1;
        bus_if.iorq_n = 1'b1;
        tick();
    endtask

    task automatic host_drain();
        for (int i = 0; i < 40 && host_q.size() > 0; i++) tick();
        check("host_drained", host_q.size(), 0);
    endtask

    task automatic tx_drain();
        for (int i = 0; i < 40 && mtx.size() > 0; i++) tick();
        check("tx_drained", mtx.size(), 0);
    endtask

    initial begin
        logic [7:0] v;
        logic [7:0] sent[6];
        logic [7:0] wb[5];
        int r;
        bus_if.override = 1'b1;
        bus_if.io_addr  = 8'h00;
        bus_if.iorq_n   = 1'b1;
        bus_if.rd_n     = 1'b1;
        bus_if.wr_n     = 1'b1;
        bus_if.io_din   = 8'h00;
        bus_if.rx_data  = 8'h00;
        bus_if.rx_valid = 1'b0;
        bus_if.rx_eof   = 1'b0;
        bus_if.tx_ready = 1'b0;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_io_dout", bus_if.io_dout, 8'h00);
        check("rst_io_oe", bus_if.io_oe, 1'b0);
        check("rst_rx_ready", bus_if.rx_ready, 1'b0);
        check("rst_tx_valid", bus_if.tx_valid, 1'b0);
        check("rst_tx_data", bus_if.tx_data, 8'h00);
        check("rst_mode", bus_if.mode, M_IDLE);
        @(negedge clk);
        reset_n = 1'b1;
        tick();

        io_read(8'd0, 1, "status_reset", v);
        check("status_reset_const", v, 8'h02);

        // Simple load ending in DONE.
        io_write(8'd2, 8'h01);
        host_q.push_back(8'h3C);
        host_q.push_back(8'hA5);
        host_drain();
        bus_if.rx_eof = 1'b1;
        io_read(8'd1, 1, "load0", v);
        check("load0_const", v, 8'h3C);
        io_read(8'd1, 1, "load1", v);
        check("load1_const", v, 8'hA5);
        tick();
        io_read(8'd0, 1, "status_done", v);
        check("status_done_const", v, 8'h36);
        check("mode_done_const", bus_if.mode, M_DONE);
        io_read(8'd1, 1, "load_empty", v);
        check("load_empty_const", v, 8'hFF);

        // Back-pressure: six bytes offered, only four fit.
        bus_if.rx_eof = 1'b0;
        io_write(8'd2, 8'h00);
        io_write(8'd2, 8'h01);
        for (int i = 0; i < 6; i++) begin
            sent[i] = 8'($urandom);
            host_q.push_back(sent[i]);
        end
        repeat (12) tick();
        check("bp_rx_ready_low", bus_if.rx_ready, 1'b0);
        check("bp_host_left", host_q.size(), 2);
        for (int i = 0; i < 6; i++) begin
            io_read(8'd1, 1, "bp_read", v);
            check("bp_order", v, sent[i]);
        end

        // Long RD: one access pops exactly one byte.
        sent[0] = 8'($urandom);
        sent[1] = 8'($urandom);
        host_q.push_back(sent[0]);
        host_q.push_back(sent[1]);
        host_drain();
        io_read(8'd1, 6, "hold_read", v);
        check("hold_first", v, sent[0]);
        io_read(8'd1, 1, "hold_next", v);
        check("hold_second", v, sent[1]);
        io_read(8'd0, 1, "hold_status", v);
        check("hold_empty_bit", v[0], 1'b0);

        // Randomized mix of host traffic and CPU reads in LOAD.
        for (int i = 0; i < 24; i++) begin
            r = $urandom_range(0, 3);
            case (r)
                0: host_q.push_back(8'($urandom));
                1: io_read(8'd1, $urandom_range(1, 3), "rnd_data", v);
                2: io_read(8'd0, 1, "rnd_status", v);
                default: tick();
            endcase
        end
        host_drain();
        for (int i = 0; i < 8 && mrx.size() > 0; i++) io_read(8'd1, 1, "rnd_flush", v);
        check("rnd_model_empty", mrx.size(), 0);

        // Save: five writes into a four-entry FIFO with the host stalled.
        io_write(8'd2, 8'h02);
        bus_if.tx_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            wb[i] = 8'($urandom);
            io_write(8'd1, wb[i]);
        end
        io_read(8'd0, 1, "save_status", v);
        check("save_full_bit", v[1], 1'b0);
        txlog.delete();
        bus_if.tx_ready = 1'b1;
        tx_drain();
        check("save_count", txlog.size(), 4);
        for (int i = 0; i < 4; i++) check("save_order", txlog[i], wb[i]);
        bus_if.tx_ready = 1'b0;

        // CTRL 00 while bytes are still queued: SAVE holds until drained.
        io_write(8'd2, 8'h02);
        for (int i = 0; i < 3; i++) io_write(8'd1, 8'($urandom));
        io_write(8'd2, 8'h00);
        check("pend_mode_save", bus_if.mode, M_SAVE);
        bus_if.tx_ready = 1'b1;
        tx_drain();
        repeat (2) tick();
        check("pend_mode_idle", bus_if.mode, M_IDLE);
        bus_if.tx_ready = 1'b0;

        // Override low: bus ignored, tx contents kept and later drained.
        io_write(8'd2, 8'h02);
        wb[0] = 8'($urandom);
        wb[1] = 8'($urandom);
        io_write(8'd1, wb[0]);
        io_write(8'd1, wb[1]);
        bus_if.override = 1'b0;
        tick();
        io_write(8'd1, 8'h55);
        io_read(8'd1, 1, "ovr_read", v);
        check("ovr_mode_idle", bus_if.mode, M_IDLE);
        bus_if.override = 1'b1;
        txlog.delete();
        bus_if.tx_ready = 1'b1;
        tx_drain();
        check("ovr_count", txlog.size(), 2);
        for (int i = 0; i < 2 && i < txlog.size(); i++) check("ovr_order", txlog[i], wb[i]);
        bus_if.tx_ready = 1'b0;

`ifdef HYPER_TAPE_CHECKSUM_EN
        io_write(8'd2, 8'h01);
        host_q.push_back(8'hF0);
        host_q.push_back(8'h20);
        host_drain();
        io_read(8'd1, 1, "csum_ld0", v);
        io_read(8'd1, 1, "csum_ld1", v);
        io_read(8'd3, 1, "csum_sum", v);
        check("csum_sum_const", v, 8'h10);
        io_read(8'd0, 1, "csum_status", v);
        check("csum_nz_bit", v[6], 1'b1);
        io_write(8'd2, 8'h00);
        io_read(8'd3, 1, "csum_clear", v);
        check("csum_clear_const", v, 8'h00);
`else
        io_read(8'd3, 1, "ofs3_undecoded", v);
        io_read(8'd0, 1, "status_no_csum", v);
        check("csum_bit_zero", v[6], 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "bench timeout");
    end
endmodule
